// File: rtl/audio_pkg.sv
// Shared audio-path types: sample format, receiver window size and the
// streaming state shared by the FFT front-end blocks.
package audio_pkg;

    localparam int SAMPLE_W = 18;
    localparam int N_PTS    = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        IDLE,
        STREAM
    } stream_state_t;

endpackage

// File: rtl/fft_frame_streamer.sv
// Snapshots the receiver's 16-sample window every HOP strobes and streams it
// oldest-first to the FFT over valid/ready, flagging frames that arrive too early.
module fft_frame_streamer #(
    parameter int DATA_W = audio_pkg::SAMPLE_W,
    parameter int N_PTS  = audio_pkg::N_PTS,
    parameter int HOP    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      new_t,
    input  logic [N_PTS*DATA_W-1:0]   win,
    output logic signed [DATA_W-1:0]  out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      overflow
);
    import audio_pkg::*;

    localparam logic [15:0] HOP_LAST = 16'(HOP - 1);
    localparam logic [3:0]  IDX_LAST = 4'(N_PTS - 1);

    stream_state_t             r_state;
    logic [15:0]               r_hop_cnt;
    logic [3:0]                r_idx;
    logic signed [DATA_W-1:0]  r_snap [N_PTS];
    logic signed [DATA_W-1:0]  r_data;
    logic                      r_valid;
    logic                      r_sop;
    logic                      r_eop;
    logic                      r_overflow;

    logic                      w_trigger;
    logic                      w_handshake;
    logic                      w_last_beat;
    logic                      w_capture;
    logic                      w_drop;
    logic [3:0]                w_idx_next;
    logic signed [DATA_W-1:0]  w_next_data;
    logic signed [DATA_W-1:0]  w_oldest;

    assign w_trigger   = new_t && (r_hop_cnt == HOP_LAST);
    assign w_handshake = r_valid && out_ready;
    assign w_last_beat = w_handshake && (r_idx == IDX_LAST);
    // A new frame may start on the same edge that retires the previous eop.
    assign w_capture   = w_trigger && ((r_state == IDLE) || w_last_beat);
    assign w_drop      = w_trigger && !w_capture;
    assign w_idx_next  = r_idx + 4'd1;
    assign w_next_data = r_snap[IDX_LAST - w_idx_next];
    assign w_oldest    = win[(N_PTS-1)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_hop_cnt  <= '0;
            r_idx      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (new_t) begin
                r_hop_cnt <= w_trigger ? 16'd0 : r_hop_cnt + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_capture) begin
                r_state <= STREAM;
                r_idx   <= '0;
                r_data  <= w_oldest;
                r_valid <= 1'b1;
                r_sop   <= 1'b1;
                r_eop   <= 1'b0;
            end else if (w_handshake) begin
                if (r_idx == IDX_LAST) begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_sop   <= 1'b0;
                    r_eop   <= 1'b0;
                end else begin
                    r_idx  <= w_idx_next;
                    r_data <= w_next_data;
                    r_sop  <= 1'b0;
                    r_eop  <= (w_idx_next == IDX_LAST);
                end
            end
        end
    end

    // Snapshot is pure data; it is only meaningful while a frame is streaming.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < N_PTS; k++) begin
                r_snap[k] <= win[k*DATA_W +: DATA_W];
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_sop   = r_sop;
    assign out_eop   = r_eop;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Bench for fft_frame_streamer: three instances (HOP = 16, 4, 1) driven with
// random windows and checked against a frame model built from the window.
module tb_fft_frame_streamer;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    nt;
    logic [2:0]    rdy;
    logic [287:0]  win;
    logic [17:0]   od [3];
    logic [2:0]    ov;
    logic [2:0]    sop;
    logic [2:0]    eop;
    logic [2:0]    ofl;

    int            checks = 0;
    int            errors = 0;
    logic [17:0]   exp_f [16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fft_frame_streamer #(
            .DATA_W(18),
            .N_PTS (16),
            .HOP   (g == 0 ? 16 : (g == 1 ? 4 : 1))
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .new_t    (nt[g]),
            .win      (win),
            .out_data (od[g]),
            .out_valid(ov[g]),
            .out_ready(rdy[g]),
            .out_sop  (sop[g]),
            .out_eop  (eop[g]),
            .overflow (ofl[g])
        );
    end

    function automatic logic [287:0] rand_win();
        logic [287:0] r;
        for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Expected frame: window samples ordered oldest (t15) to newest (t0).
    task automatic model_frame(input logic [287:0] w);
        for (int k = 0; k < 16; k++) exp_f[15-k] = w[k*18 +: 18];
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int g);
        nt[g] = 1'b1;
        cyc();
        nt[g] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        nt    = '0;
        rdy   = '0;
        win   = rand_win();
        cyc();
        cyc();
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (ov[g] !== 1'b0 || od[g] !== 18'h0 || sop[g] !== 1'b0 || eop[g] !== 1'b0 || ofl[g] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: valid=%b data=%h sop=%b eop=%b ovf=%b, expected all zero",
                         g, ov[g], od[g], sop[g], eop[g], ofl[g]);
            end
        end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        logic seen_valid;
        rdy[0] = 1'b1;
        for (int k = 0; k < 16; k++) win[k*18 +: 18] = 18'(k + 1);
        seen_valid = 1'b0;
        for (int s = 0; s < 15; s++) begin
            strobe(0);
            seen_valid |= ov[0];
            cyc();
            seen_valid |= ov[0];
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_no_early_frame: valid seen=%b, expected 0 before 16th strobe", seen_valid);
        end
        strobe(0);
        win = rand_win();
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (ov[0] !== 1'b1 || od[0] !== 18'(16 - j) || sop[0] !== (j == 0) || eop[0] !== (j == 15)) begin
                errors++;
                $display("FAIL basic_beat%0d: valid=%b data=%h sop=%b eop=%b, expected valid=1 data=%h sop=%b eop=%b",
                         j, ov[0], od[0], sop[0], eop[0], 18'(16 - j), (j == 0), (j == 15));
            end
            cyc();
        end
        checks++;
        if (ov[0] !== 1'b0 || ofl[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: valid=%b ovf=%b, expected 0 0", ov[0], ofl[0]);
        end
    endtask

    task automatic test_stall();
        logic [287:0] w;
        int j;
        int n;
        logic r;
        rdy[1] = 1'b0;
        w = rand_win();
        win = w;
        model_frame(w);
        for (int s = 0; s < 3; s++) begin
            strobe(1);
            cyc();
        end
        checks++;
        if (ov[1] !== 1'b0) begin
            errors++;
            $display("FAIL stall_pre_trigger: valid=%b, expected 0", ov[1]);
        end
        strobe(1);
        win = rand_win();
        j = 0;
        n = 0;
        while (j < 16 && n < 200) begin
            checks++;
            if (ov[1] !== 1'b1 || od[1] !== exp_f[j] || sop[1] !== (j == 0) || eop[1] !== (j == 15)) begin
                errors++;
                $display("FAIL stall_beat%0d_cyc%0d: valid=%b data=%h sop=%b eop=%b, expected valid=1 data=%h sop=%b eop=%b",
                         j, n, ov[1], od[1], sop[1], eop[1], exp_f[j], (j == 0), (j == 15));
            end
            r = (n < 8) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
            rdy[1] = r;
            cyc();
            if (r) j++;
            n++;
        end
        rdy[1] = 1'b0;
        checks++;
        if (j != 16 || ov[1] !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: beats=%0d valid=%b, expected 16 beats then valid=0", j, ov[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [287:0] wa;
        logic [287:0] wb;
        rdy[1] = 1'b1;
        wa = rand_win();
        wb = rand_win();
        for (int s = 0; s < 3; s++) strobe(1);
        win = wa;
        model_frame(wa);
        strobe(1);
        win = rand_win();
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (ov[1] !== 1'b1 || od[1] !== exp_f[j] || sop[1] !== (j == 0) || eop[1] !== (j == 15)) begin
                errors++;
                $display("FAIL b2b_a_beat%0d: valid=%b data=%h sop=%b eop=%b, expected valid=1 data=%h sop=%b eop=%b",
                         j, ov[1], od[1], sop[1], eop[1], exp_f[j], (j == 0), (j == 15));
            end
            if (j == 3 || j == 7 || j == 11) nt[1] = 1'b1;
            if (j == 15) begin
                nt[1] = 1'b1;
                win = wb;
            end
            cyc();
            nt[1] = 1'b0;
        end
        win = rand_win();
        model_frame(wb);
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (ov[1] !== 1'b1 || od[1] !== exp_f[j] || sop[1] !== (j == 0) || eop[1] !== (j == 15) || ofl[1] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_b_beat%0d: valid=%b data=%h sop=%b eop=%b ovf=%b, expected valid=1 data=%h sop=%b eop=%b ovf=0",
                         j, ov[1], od[1], sop[1], eop[1], ofl[1], exp_f[j], (j == 0), (j == 15));
            end
            cyc();
        end
        checks++;
        if (ov[1] !== 1'b0 || ofl[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: valid=%b ovf=%b, expected 0 0", ov[1], ofl[1]);
        end
        rdy[1] = 1'b0;
    endtask

    task automatic test_overflow();
        logic [287:0] w;
        rdy[2] = 1'b0;
        w = rand_win();
        win = w;
        model_frame(w);
        strobe(2);
        win = rand_win();
        checks++;
        if (ov[2] !== 1'b1 || od[2] !== exp_f[0] || sop[2] !== 1'b1 || ofl[2] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_first_frame: valid=%b data=%h sop=%b ovf=%b, expected valid=1 data=%h sop=1 ovf=0",
                     ov[2], od[2], sop[2], ofl[2], exp_f[0]);
        end
        cyc();
        cyc();
        strobe(2);
        checks++;
        if (ofl[2] !== 1'b1 || ov[2] !== 1'b1 || od[2] !== exp_f[0] || sop[2] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: ovf=%b valid=%b data=%h sop=%b, expected ovf=1 valid=1 data=%h sop=1",
                     ofl[2], ov[2], od[2], sop[2], exp_f[0]);
        end
        rdy[2] = 1'b1;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (ov[2] !== 1'b1 || od[2] !== exp_f[j] || sop[2] !== (j == 0) || eop[2] !== (j == 15)) begin
                errors++;
                $display("FAIL ovf_beat%0d: valid=%b data=%h sop=%b eop=%b, expected valid=1 data=%h sop=%b eop=%b",
                         j, ov[2], od[2], sop[2], eop[2], exp_f[j], (j == 0), (j == 15));
            end
            cyc();
        end
        checks++;
        if (ov[2] !== 1'b0 || ofl[2] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: valid=%b ovf=%b, expected valid=0 ovf=1", ov[2], ofl[2]);
        end
        rdy[2] = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [287:0] w;
        logic seen_valid;
        rdy[0] = 1'b0;
        w = rand_win();
        win = w;
        model_frame(w);
        for (int s = 0; s < 16; s++) strobe(0);
        win = rand_win();
        for (int s = 0; s < 21; s++) strobe(0);
        checks++;
        if (ofl[0] !== 1'b1 || ov[0] !== 1'b1 || od[0] !== exp_f[0]) begin
            errors++;
            $display("FAIL rstmid_setup: ovf=%b valid=%b data=%h, expected ovf=1 valid=1 data=%h",
                     ofl[0], ov[0], od[0], exp_f[0]);
        end
        rdy[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (ov[0] !== 1'b1 || od[0] !== exp_f[j] || sop[0] !== (j == 0) || eop[0] !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_beat%0d: valid=%b data=%h sop=%b eop=%b, expected valid=1 data=%h sop=%b eop=0",
                         j, ov[0], od[0], sop[0], eop[0], exp_f[j], (j == 0));
            end
            if (j < 7) cyc();
        end
        reset = 1'b0;
        cyc();
        checks++;
        if (ov[0] !== 1'b0 || ofl[0] !== 1'b0 || sop[0] !== 1'b0 || eop[0] !== 1'b0 || od[0] !== 18'h0) begin
            errors++;
            $display("FAIL rstmid_abort: valid=%b ovf=%b sop=%b eop=%b data=%h, expected all zero",
                     ov[0], ofl[0], sop[0], eop[0], od[0]);
        end
        reset = 1'b1;
        w = rand_win();
        win = w;
        model_frame(w);
        seen_valid = 1'b0;
        for (int s = 0; s < 15; s++) begin
            strobe(0);
            seen_valid |= ov[0];
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_hop_restart: valid seen=%b, expected 0 before 16 fresh strobes", seen_valid);
        end
        strobe(0);
        win = rand_win();
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (ov[0] !== 1'b1 || od[0] !== exp_f[j] || sop[0] !== (j == 0) || eop[0] !== (j == 15)) begin
                errors++;
                $display("FAIL rstmid_refr_beat%0d: valid=%b data=%h sop=%b eop=%b, expected valid=1 data=%h sop=%b eop=%b",
                         j, ov[0], od[0], sop[0], eop[0], exp_f[j], (j == 0), (j == 15));
            end
            cyc();
        end
    endtask

    task automatic test_extremes();
        logic [287:0] w;
        rdy[0] = 1'b1;
        w = rand_win();
        w[15*18 +: 18] = 18'h20000;
        w[0 +: 18]     = 18'h1FFFF;
        win = w;
        model_frame(w);
        for (int s = 0; s < 16; s++) strobe(0);
        win = rand_win();
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (ov[0] !== 1'b1 || od[0] !== exp_f[j] || sop[0] !== (j == 0) || eop[0] !== (j == 15)) begin
                errors++;
                $display("FAIL extreme_beat%0d: valid=%b data=%h sop=%b eop=%b, expected valid=1 data=%h sop=%b eop=%b",
                         j, ov[0], od[0], sop[0], eop[0], exp_f[j], (j == 0), (j == 15));
            end
            if (j == 0) begin
                checks++;
                if (od[0] !== 18'h20000) begin
                    errors++;
                    $display("FAIL extreme_min: data=%h, expected 20000", od[0]);
                end
            end
            if (j == 15) begin
                checks++;
                if (od[0] !== 18'h1FFFF) begin
                    errors++;
                    $display("FAIL extreme_max: data=%h, expected 1ffff", od[0]);
                end
            end
            cyc();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nt     = '0;
        rdy    = '0;
        reset  = 1'b0;
        win    = '0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_extremes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
